// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit per cycle; SERIAL_ADDER_SUB_EN adds a sub port (a-b)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, res, res_nx, b_cap;
  logic [CW-1:0] cnt;
  logic carry, carry_nx, bit_s, c_cap, last;
  // operand conditioning at capture: subtraction is a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_cap = sub ? ~b : b;
    c_cap = sub | c_in;
  end
`else
  always_comb begin
    b_cap = b;
    c_cap = c_in;
  end
`endif
  // one full-adder slice on the current LSBs; result bit enters at the MSB
  always_comb begin
    bit_s = sa[0] ^ sb[0] ^ carry;
    carry_nx = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    res_nx = WIDTH'({bit_s, res} >> 1);
    last = cnt == CW'(WIDTH - 1);
  end
  // next-state and status outputs; start is only honoured in IDLE
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // datapath: capture at accept, shift during RUN, publish result on the last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      res <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      c_out <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= b_cap;
      res <= '0;
      carry <= c_cap;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      res <= res_nx;
      carry <= carry_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum <= res_nx;
        c_out <= carry_nx;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, co8;
  logic [7:0] sum8;
  logic start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic c1 = 1'b0, busy1, done1, co1;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub8 = 1'b0;
  logic sub1 = 1'b0;
`endif
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(c8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .c_out(co8));

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(c1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1));

  // runs one 8-bit operation, scrambling operands after accept; bounded to 12 cycles
  task automatic do_op8(input logic [7:0] ia, ib, input logic ic, input bit hold,
                        output int bcnt, output int dat, output int dcnt,
                        output logic [7:0] s, output logic co);
    bcnt = 0; dat = 0; dcnt = 0; s = 'x; co = 1'bx;
    @(negedge clk);
    a8 = ia; b8 = ib; c8 = ic; start8 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!hold) start8 = 1'b0;
      a8 = ~a8; b8 = b8 + 8'h37; c8 = ~c8;
      if (busy8) bcnt++;
      if (done8) begin
        dcnt++;
        if (dat == 0) begin dat = k; s = sum8; co = co8; end
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
    n_checks++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum8); end
    n_checks++; if (co8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", co8); end
    n_checks++; if (busy1 !== 1'b0 || sum1 !== 1'b0) begin n_fail++; $display("FAIL reset_w1 got busy=%b sum=%b want 0 0", busy1, sum1); end
    start8 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_idle got busy=%b want 0", busy8); end
  endtask

  task automatic check_op(input string nm, input logic [7:0] ia, ib, input logic ic, input bit hold,
                          input logic [7:0] es, input logic eco);
    int bcnt, dat, dcnt;
    logic [7:0] s;
    logic co;
    do_op8(ia, ib, ic, hold, bcnt, dat, dcnt, s, co);
    n_checks++; if (s !== es) begin n_fail++; $display("FAIL %s_sum got %h want %h", nm, s, es); end
    n_checks++; if (co !== eco) begin n_fail++; $display("FAIL %s_cout got %b want %b", nm, co, eco); end
    n_checks++; if (dat != 9) begin n_fail++; $display("FAIL %s_done_at got %0d want 9", nm, dat); end
    n_checks++; if (bcnt != 8) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 8", nm, bcnt); end
    n_checks++; if (dcnt != 1) begin n_fail++; $display("FAIL %s_done_pulses got %0d want 1", nm, dcnt); end
  endtask

  task automatic test_wrap;
    check_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_start_hold;
    check_op("hold", 8'h5A, 8'h25, 1'b1, 1'b1, 8'h80, 1'b0);
  endtask

  task automatic test_patterns;
    check_op("pat_a5", 8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);
    check_op("pat_c3", 8'hC3, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1);
    check_op("pat_7f", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);
    check_op("pat_80", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);
  endtask

  task automatic test_abort;
    int dcnt = 0;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    n_checks++; if (sum8 !== 8'h01 || co8 !== 1'b1) begin n_fail++; $display("FAIL abort_hold got %h/%b want 01/1", sum8, co8); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy8); end
    n_checks++; if (sum8 !== 8'h00 || co8 !== 1'b0) begin n_fail++; $display("FAIL abort_clear got %h/%b want 00/0", sum8, co8); end
    for (int k = 0; k < 12; k++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    n_checks++; if (dcnt != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", dcnt); end
    n_checks++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL abort_sum_after got %h want 00", sum8); end
    check_op("after_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
  endtask

  task automatic test_back_to_back;
    int d1 = 0, d2 = 0;
    logic [7:0] s1 = 'x, s2 = 'x;
    logic co2 = 1'bx;
    bit held_ok = 1'b1;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; c8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (d1 != 0 && d2 == 0 && k > d1) begin
        if (done8) begin d2 = k; s2 = sum8; co2 = co8; end
        else if (sum8 !== 8'h33) held_ok = 1'b0;
      end
      if (done8 && d1 == 0) begin d1 = k; s1 = sum8; end
      if (d1 != 0 && k == d1 + 1) begin a8 = 8'h0F; b8 = 8'h01; c8 = 1'b1; start8 = 1'b1; end
      if (d1 != 0 && k == d1 + 2) begin start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; end
    end
    start8 = 1'b0;
    n_checks++; if (d1 != 9 || s1 !== 8'h33) begin n_fail++; $display("FAIL b2b_first got at=%0d sum=%h want 9 33", d1, s1); end
    n_checks++; if (d2 != 19) begin n_fail++; $display("FAIL b2b_second_at got %0d want 19", d2); end
    n_checks++; if (s2 !== 8'h11 || co2 !== 1'b0) begin n_fail++; $display("FAIL b2b_second got %h/%b want 11/0", s2, co2); end
    n_checks++; if (!held_ok) begin n_fail++; $display("FAIL b2b_sum_held got changed want 33 held"); end
  endtask

  task automatic test_width1;
    logic [7:0] st = 8'h96;
    logic [7:0] ct = 8'hE8;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; c1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; c1 = ~c1;
      n_checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_fail++; $display("FAIL w1_run_%0d got busy=%b done=%b want 1 0", i, busy1, done1); end
      @(negedge clk);
      n_checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL w1_done_%0d got done=%b busy=%b want 1 0", i, done1, busy1); end
      n_checks++; if (sum1 !== st[i] || co1 !== ct[i]) begin n_fail++; $display("FAIL w1_res_%0d got %b/%b want %b/%b", i, sum1, co1, st[i], ct[i]); end
    end
    @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    sub8 = 1'b1;
    check_op("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1);
    check_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'hFF, 1'b0);
    sub8 = 1'b0;
    check_op("sub_off", 8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
  endtask
`endif

  initial begin
    test_reset;
    test_wrap;
    test_start_hold;
    test_patterns;
    test_abort;
    test_back_to_back;
    test_width1;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
